// File: rtl/pe_job_sched.sv
// ---------------------------------------------------------------------------
// pe_job_sched
//
// Job sequencer for the sparse-conv PE datapath. Accepts one layer command,
// then walks every (weight set, IA row) job with the weight set as the outer
// loop and the row as the inner loop. Each job goes through four phases:
// bundle load, PE start/finish handshake, release of the start level, and
// hand-off of the OA row to writeback.
//
// Ports:
//   i_clk, i_rst        clock and synchronous active-high reset
//   i_cmd_valid         layer command present (only looked at in IDLE)
//   o_cmd_ready         high only in IDLE
//   i_cmd_num_rows      rows to process, clamped to NUM_ROWS when latched
//   i_cmd_num_wsets     weight sets to process, clamped to NUM_WSETS
//   o_ld_req            bundle load request for the current job
//   o_ld_row/o_ld_wset  row and weight set of the current job
//   i_ld_done           bundle is stable on the PE inputs
//   o_pe_start          level start to the PE
//   i_pe_finish         PE finish level
//   o_wb_valid          OA row ready; row/set are on o_ld_row/o_ld_wset
//   i_wb_ready          writeback accepts the row
//   o_busy              high in any state other than IDLE
//   o_done              one-cycle pulse when a command completes
//   o_err               sticky watchdog error
//
// Build option:
//   PE_SCHED_TIMEOUT_EN  when defined, a watchdog aborts a job that spends
//                        TIMEOUT cycles in RUN+RELEASE and sets o_err.
//                        When undefined, RUN/RELEASE wait indefinitely and
//                        o_err is tied low.
// ---------------------------------------------------------------------------
module pe_job_sched #(
    parameter int NUM_ROWS  = 16,
    parameter int NUM_WSETS = 3,
    parameter int TIMEOUT   = 1023
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_cmd_valid,
    output logic                        o_cmd_ready,
    input  logic [$clog2(NUM_ROWS):0]   i_cmd_num_rows,
    input  logic [1:0]                  i_cmd_num_wsets,
    output logic                        o_ld_req,
    output logic [$clog2(NUM_ROWS)-1:0] o_ld_row,
    output logic [1:0]                  o_ld_wset,
    input  logic                        i_ld_done,
    output logic                        o_pe_start,
    input  logic                        i_pe_finish,
    output logic                        o_wb_valid,
    input  logic                        i_wb_ready,
    output logic                        o_busy,
    output logic                        o_done,
    output logic                        o_err
);

    localparam int ROW_W = $clog2(NUM_ROWS);
    localparam int CNT_W = ROW_W + 1;
    localparam logic [CNT_W-1:0] MAX_ROWS  = CNT_W'(NUM_ROWS);
    localparam logic [1:0]       MAX_WSETS = 2'(NUM_WSETS);

    // Reject parameter sets the fixed-width ports cannot represent.
    if (NUM_ROWS < 2 || NUM_WSETS < 1 || NUM_WSETS > 3 || TIMEOUT < 1) begin : g_bad_params
        $error("pe_job_sched: unsupported parameter combination");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_RELEASE,
        S_WB
    } state_t;

    state_t           state_q, state_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [1:0]       wset_q, wset_d;
    logic [CNT_W-1:0] num_rows_q, num_rows_d;
    logic [1:0]       num_wsets_q, num_wsets_d;
    logic             done_q, done_d;

    logic [CNT_W-1:0] rows_clamped;
    logic [1:0]       wsets_clamped;
    logic             last_row;
    logic             last_wset;
    logic             tmo_hit;

`ifdef PE_SCHED_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             err_q, err_d;

    // Watchdog: counts every cycle spent in RUN or RELEASE and is held at
    // zero elsewhere, so it always starts fresh when a job enters LOAD.
    // Hitting TIMEOUT flags a sticky error and aborts the command.
    always_comb begin
        tmo_d   = '0;
        tmo_hit = 1'b0;
        if (state_q == S_RUN || state_q == S_RELEASE) begin
            tmo_d   = tmo_q + 1'b1;
            tmo_hit = (tmo_d == TMO_W'(TIMEOUT));
        end
        err_d = err_q | tmo_hit;
    end

    // Watchdog registers; the error flag only clears on reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmo_q <= tmo_d;
            err_q <= err_d;
        end
    end

    assign o_err = err_q;
`else
    assign tmo_hit = 1'b0;
    assign o_err   = 1'b0;
`endif

    // Command clamping and end-of-loop detection. The counts are nonzero
    // whenever the loop flags are used, so num - 1 never underflows there.
    always_comb begin
        rows_clamped  = (i_cmd_num_rows > MAX_ROWS) ? MAX_ROWS : i_cmd_num_rows;
        wsets_clamped = (i_cmd_num_wsets > MAX_WSETS) ? MAX_WSETS : i_cmd_num_wsets;
        last_row      = ({1'b0, row_q} == (num_rows_q - CNT_W'(1)));
        last_wset     = (wset_q == (num_wsets_q - 2'd1));
    end

    // Next-state logic. Row/wset only change on command accept or on a WB
    // handshake, so they stay steady for the whole LOAD..WB span of a job.
    // A zero-length command completes straight from IDLE with a done pulse.
    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        wset_d      = wset_q;
        num_rows_d  = num_rows_q;
        num_wsets_d = num_wsets_q;
        done_d      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (i_cmd_valid) begin
                    num_rows_d  = rows_clamped;
                    num_wsets_d = wsets_clamped;
                    row_d       = '0;
                    wset_d      = '0;
                    if (rows_clamped == '0 || wsets_clamped == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (i_ld_done) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (tmo_hit) begin
                    state_d = S_IDLE;
                end else if (i_pe_finish) begin
                    state_d = S_RELEASE;
                end
            end
            S_RELEASE: begin
                // The PE only drops finish after it has seen start low.
                if (tmo_hit) begin
                    state_d = S_IDLE;
                end else if (!i_pe_finish) begin
                    state_d = S_WB;
                end
            end
            S_WB: begin
                if (i_wb_ready) begin
                    if (!last_row) begin
                        row_d   = row_q + 1'b1;
                        state_d = S_LOAD;
                    end else if (!last_wset) begin
                        row_d   = '0;
                        wset_d  = wset_q + 2'd1;
                        state_d = S_LOAD;
                    end else begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and job registers; reset aborts any job without a done pulse.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            row_q       <= '0;
            wset_q      <= '0;
            num_rows_q  <= '0;
            num_wsets_q <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            wset_q      <= wset_d;
            num_rows_q  <= num_rows_d;
            num_wsets_q <= num_wsets_d;
            done_q      <= done_d;
        end
    end

    assign o_cmd_ready = (state_q == S_IDLE);
    assign o_busy      = (state_q != S_IDLE);
    assign o_ld_req    = (state_q == S_LOAD);
    assign o_pe_start  = (state_q == S_RUN);
    assign o_wb_valid  = (state_q == S_WB);
    assign o_ld_row    = row_q;
    assign o_ld_wset   = wset_q;
    assign o_done      = done_q;

endmodule

// File: doc/pe_job_sched.md
# pe_job_sched

Sequencer for the sparse-conv PE datapath: accepts one layer command, then walks every (weight set, IA row) job in order. For each job it requests a bundle load into the PE input registers, runs the PE through its start/finish handshake, and hands the resulting OA row to writeback. It sits between the layer-level host FSM and one PE instance plus its IA/W buffers and OA writeback port.

## Interface
Parameters:
- NUM_ROWS, 16, IA rows per layer, equal to IA_ROW.
- NUM_WSETS, 3, maximum weight sets (S0..S2).
- TIMEOUT, 1023, maximum cycles allowed in RUN+RELEASE per job.

Ports:
- i_clk  in  1  single clock; all logic on its rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_cmd_valid  in  1  layer command present.
- o_cmd_ready  out  1  high only in IDLE.
- i_cmd_num_rows  in  $clog2(NUM_ROWS)+1  rows to process, 0..NUM_ROWS.
- i_cmd_num_wsets  in  2  weight sets to process, 0..NUM_WSETS.
- o_ld_req  out  1  load request for the current job bundle.
- o_ld_row  out  $clog2(NUM_ROWS)  IA row (i_ia_h) of the current job.
- o_ld_wset  out  2  weight set (i_w_s) of the current job.
- i_ld_done  in  1  bundle is stable on the PE inputs.
- o_pe_start  out  1  level start to the PE.
- i_pe_finish  in  1  PE finish level.
- o_wb_valid  out  1  OA row ready to write back; the row and set are on o_ld_row/o_ld_wset.
- i_wb_ready  in  1  writeback accepts the row.
- o_busy  out  1  high in any state other than IDLE.
- o_done  out  1  one-cycle pulse when a command completes.
- o_err  out  1  sticky watchdog error.

## Operation
- States: IDLE, LOAD, RUN, RELEASE, WB.
- IDLE: when i_cmd_valid && o_cmd_ready, latch num_rows and num_wsets, and clear row and wset.
  - If either latched count is 0: pulse o_done the next cycle and stay in IDLE.
  - Otherwise go to LOAD.
- LOAD: o_ld_req=1. When i_ld_done is seen, drop o_ld_req and go to RUN.
- RUN: o_pe_start=1. When i_pe_finish=1, drop start and go to RELEASE.
- RELEASE: o_pe_start=0. Wait for i_pe_finish=0.
  - PE contract: the PE deasserts finish after it sees start low.
  - Then go to WB.
- WB: o_wb_valid=1 until i_wb_ready, then advance:
  - row < num_rows-1: row++, go to LOAD.
  - Otherwise, if wset < num_wsets-1: row=0, wset++, go to LOAD.
  - Otherwise: o_done=1 for one cycle, go to IDLE.
- Job order: wset is the outer loop, row is the inner loop. For example, (0,0),(0,1)..(0,R-1),(1,0)...
- Counts above their maximum clamp to NUM_ROWS/NUM_WSETS when latched.
- o_ld_row/o_ld_wset hold steady from LOAD entry through WB exit.
- i_cmd_valid is ignored outside IDLE.
- i_pe_finish already high on LOAD entry is ignored until RUN.

## Timing
- Reset values: o_cmd_ready=1 (IDLE), all other outputs 0, row=wset=0.
- Reset mid-job aborts immediately and returns to IDLE on the next edge. No o_done.
- Accept at edge N: o_ld_req high in cycle N+1.
- Each state's exit condition is sampled at the clock edge. With every input responding in the same cycle, a job takes 4 cycles: LOAD, RUN, RELEASE, WB.
- Total best-case latency: 4·rows·wsets cycles to the last WB, then o_done in the cycle after the final WB handshake.
- After o_done, o_cmd_ready is 1 in that same cycle, so back-to-back commands are allowed.

## Configuration
- PE_SCHED_TIMEOUT_EN defined:
  - A counter of $clog2(TIMEOUT+1) bits runs in RUN and RELEASE and clears on LOAD entry.
  - When it reaches TIMEOUT: o_err←1 (sticky until i_rst), o_pe_start←0, go to IDLE, no o_done.
- Not defined: no counter; RUN/RELEASE wait indefinitely and o_err is tied to 0.

## Test plan
- Cmd rows=2, wsets=1, all handshakes instant → jobs (0,0),(0,1); o_wb_valid at cycles 4 and 8 after accept; o_done at cycle 9.
- Cmd rows=16, wsets=3 → 48 WB handshakes in wset-major order; o_done pulses exactly once.
- Cmd rows=0, wsets=2 → o_done the next cycle, no o_ld_req/o_pe_start, o_cmd_ready stays 1.
- PE holds finish high for 5 cycles after start drops → no WB until finish falls; o_pe_start never re-asserts early.
- i_rst asserted in RUN → next cycle o_pe_start=0, state IDLE, o_busy=0, no o_done.
- With PE_SCHED_TIMEOUT_EN and TIMEOUT=8, PE never finishes → o_err=1 after 8 RUN cycles, IDLE, sticky until i_rst.
